// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared constants and state type for the icache line-refill AXI read bridge.
// A line is one 4-beat INCR burst of 32-bit beats.
package icache_axi_rd_bridge_pkg;

    localparam logic [7:0] ICACHE_ARLEN   = 8'd3;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BEATS = 4;
    localparam int BEAT_W     = 32;
    localparam int LINE_W     = LINE_BEATS * BEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } bridge_state_e;

    // Clear the byte-within-line offset so every burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// Icache request/response signals plus the AXI4 AR/R channel of the refill bridge.
// master = bridge side, slave = icache + AXI slave side.
interface icache_axi_rd_bridge_if
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int AXI_ID_W = 4
) ();

    logic                cpu_ren;
    logic [31:0]         cpu_raddr;
    logic                dev_rrdy;
    logic                ren_received;
    logic                dev_rvalid;
    logic [LINE_W-1:0]   dev_rdata;
    logic                flush_flag_valid;

    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        input  cpu_ren, cpu_raddr, arready, rdata, rresp, rlast, rvalid,
        output dev_rrdy, ren_received, dev_rvalid, dev_rdata, flush_flag_valid,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output cpu_ren, cpu_raddr, arready, rdata, rresp, rlast, rvalid,
        input  dev_rrdy, ren_received, dev_rvalid, dev_rdata, flush_flag_valid,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one icache line request into a single 4-beat AXI4 INCR read burst and
// returns the assembled 128-bit line with a one-cycle dev_rvalid pulse.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int                  AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    icache_axi_rd_bridge_if.master bus
);

    bridge_state_e                        r_state;
    logic [1:0]                           r_cnt;
    logic [LINE_BEATS-1:0][BEAT_W-1:0]    r_buf;
    logic [31:0]                          r_araddr;
    logic                                 r_arvalid;
    logic                                 r_dev_rvalid;
    logic [LINE_W-1:0]                    r_dev_rdata;

    logic                                 w_idle;
    logic                                 w_accept;
    logic                                 w_last_beat;
    logic [LINE_BEATS-1:0][BEAT_W-1:0]    w_line;
    logic                                 w_unused;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = bus.cpu_ren & w_idle;
    assign w_last_beat = (r_state == ST_R) & bus.rvalid & (r_cnt == 2'd3);
    assign w_unused    = ^{bus.rresp, bus.rlast, bus.cpu_raddr[3:0]};

    // Buffer with the current beat merged in, so the final beat can be
    // registered straight into dev_rdata on its own handshake edge.
    always_comb begin
        w_line = r_buf;
        for (int k = 0; k < LINE_BEATS; k++) begin
            if (bus.rvalid && (r_cnt == 2'(k))) begin
                w_line[k] = bus.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_buf        <= '0;
            r_araddr     <= 32'd0;
            r_arvalid    <= 1'b0;
            r_dev_rvalid <= 1'b0;
            r_dev_rdata  <= '0;
        end else begin
            r_dev_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_araddr  <= line_align(bus.cpu_raddr);
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_cnt     <= 2'd0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    // Beat count alone ends the burst; rlast is not trusted.
                    if (bus.rvalid) begin
                        r_buf[r_cnt] <= bus.rdata;
                        r_cnt        <= r_cnt + 2'd1;
                    end
                    if (w_last_beat) begin
                        r_dev_rvalid <= 1'b1;
                        r_dev_rdata  <= w_line;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dev_rrdy         = w_idle;
    assign bus.ren_received     = w_accept;
    assign bus.dev_rvalid       = r_dev_rvalid;
    assign bus.dev_rdata        = r_dev_rdata;
    // The icache drops the next line if it flushes while this is high.
    assign bus.flush_flag_valid = w_accept | (r_state == ST_AR) | (r_state == ST_R);

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = ICACHE_ARLEN;
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = (r_state == ST_R);

endmodule
